nsl_sample_assembler: RTL and testbench

Upstream feeder for `nsl_ids`. Accepts a serial stream of raw feature values, one per beat, and standardizes each as (x − mean[i]) · inv_std[i]. It assembles PC_NUM consecutive beats into one feature vector and presents it on `input_samples` with a valid/ready handshake. Storage is ping-pong double-buffered, so a new frame can fill while the previous vector waits for the consumer.

---
 rtl/nsl_sample_assembler.sv | 114 +++++++++++
 tb/tb_nsl_sample_assembler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nsl_sample_assembler.sv
// Serial-to-vector assembler: standardizes raw feature beats and packs
// PC_NUM of them into a double-buffered vector for the nsl_ids consumer.
// Ports: clk/reset; mean_in, inv_std_in (per-feature constants);
// feat_valid/feat_data/feat_last/feat_ready (beat input);
// vec_valid/vec_ready/input_samples (vector output);
// frame_error (drop pulse); sample_count (vectors handed off).
module nsl_sample_assembler #(
  parameter int PC_NUM  = 32,
  parameter int FP_SIZE = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  real              mean_in    [0:PC_NUM-1],
  input  real              inv_std_in [0:PC_NUM-1],
  input  logic             feat_valid,
  input  real              feat_data,
  input  logic             feat_last,
  output logic             feat_ready,
  output logic             vec_valid,
  input  logic             vec_ready,
  output real              input_samples [0:PC_NUM-1],
  output logic             frame_error,
  output logic [CNT_W-1:0] sample_count
);

  localparam int IW = (PC_NUM > 1) ? $clog2(PC_NUM) : 1;
  localparam logic [IW-1:0] LAST = IW'(PC_NUM - 1);

  typedef enum logic {FILL, RESYNC} state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic               wr_sel;
  logic               rd_sel;
  logic [1:0]         full;
  logic [FP_SIZE-1:0] bank [0:1][0:PC_NUM-1];
  logic               take;
  logic               give;

  // Ready only looks at the write buffer; a handoff frees a buffer
  // one cycle later, so there is no combinational path from vec_ready.
  assign feat_ready = !full[wr_sel] && !reset;
  assign vec_valid  = full[rd_sel];
  assign take       = feat_valid && feat_ready;
  assign give       = vec_valid && vec_ready;

  always_comb begin
    for (int i = 0; i < PC_NUM; i++) begin
      input_samples[i] = $bitstoreal(bank[rd_sel][i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      idx          <= '0;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      full         <= 2'b00;
      frame_error  <= 1'b0;
      sample_count <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < PC_NUM; i++) begin
          bank[b][i] <= '0;
        end
      end
    end else begin
      frame_error <= 1'b0;

      // Completion and handoff never hit the same buffer: a write needs
      // full[wr_sel]=0 while a handoff needs full[rd_sel]=1.
      if (give) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= !rd_sel;
        sample_count <= sample_count + CNT_W'(1);
      end

      if (take) begin
        unique case (state)
          FILL: begin
            bank[wr_sel][idx] <= $realtobits(
              (feat_data - mean_in[idx]) * inv_std_in[idx]);
            if (idx != LAST) begin
              if (feat_last) begin
                frame_error <= 1'b1;
                idx         <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              idx <= '0;
              if (feat_last) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
              end else begin
                frame_error <= 1'b1;
                state       <= RESYNC;
              end
            end
          end
          RESYNC: begin
            if (feat_last) begin
              state <= FILL;
              idx   <= '0;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nsl_sample_assembler.sv
// Scoreboard bench for nsl_sample_assembler: directed frames push
// expected vectors; a monitor checks each vector at handoff.
module tb_nsl_sample_assembler;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  real         mean [0:N-1];
  real         inv  [0:N-1];
  logic        feat_valid = 1'b0;
  real         feat_data = 0.0;
  logic        feat_last = 1'b0;
  logic        feat_ready;
  logic        vec_valid;
  logic        vec_ready = 1'b0;
  real         samples [0:N-1];
  logic        frame_error;
  logic [31:0] sample_count;

  int  checks = 0;
  int  fails = 0;
  int  err_cnt = 0;
  real exp_q[$];
  bit  f3_done = 1'b0;

  always #5 clk = ~clk;

  nsl_sample_assembler #(
    .PC_NUM (N),
    .FP_SIZE(64),
    .CNT_W  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mean_in      (mean),
    .inv_std_in   (inv),
    .feat_valid   (feat_valid),
    .feat_data    (feat_data),
    .feat_last    (feat_last),
    .feat_ready   (feat_ready),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .input_samples(samples),
    .frame_error  (frame_error),
    .sample_count (sample_count)
  );

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chkr(input string nm, input real act, input real req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %f required %f", nm, act, req);
    end
  endtask

  // Varied params: mean[i]=i, inv[i]=0.25 (even) / 0.5 (odd).
  // Frame f, element i is expected to standardize to f*100+i.
  function automatic real ev(input int f, input int i);
    return real'(f * 100 + i);
  endfunction

  function automatic real dv(input int f, input int i);
    return ev(f, i) * ((i % 2) ? 2.0 : 4.0) + real'(i);
  endfunction

  task automatic set_params(input bit varied);
    for (int i = 0; i < N; i++) begin
      mean[i] = varied ? real'(i) : 1.0;
      inv[i]  = varied ? ((i % 2) ? 0.5 : 0.25) : 0.5;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input real d, input bit last);
    bit acc;
    int n;
    n = 0;
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = last;
    forever begin
      @(negedge clk);
      acc = feat_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 500) begin
        checks++;
        fails++;
        $display("FAIL beat_timeout: got no feat_ready required ready");
        break;
      end
    end
    feat_valid = 1'b0;
    feat_last  = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input int last_at,
                            input bit good);
    if (good) for (int i = 0; i < N; i++) exp_q.push_back(ev(f, i));
    for (int i = 0; i < n; i++) beat(dv(f, i % N), i == last_at);
  endtask

  task automatic drain();
    int n;
    n = 0;
    vec_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!vec_valid) break;
      n++;
      if (n > 300) begin
        checks++;
        fails++;
        $display("FAIL drain_timeout: got vec_valid=1 required 0");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (frame_error) err_cnt++;

  always @(negedge clk) begin
    int  bad;
    real got;
    real want;
    real w;
    if (!reset && vec_valid && vec_ready) begin
      checks++;
      if (exp_q.size() < N) begin
        fails++;
        $display("FAIL vec_unexpected: got vector [0]=%f required none",
                 samples[0]);
      end else begin
        bad = -1;
        got = 0.0;
        want = 0.0;
        for (int i = 0; i < N; i++) begin
          w = exp_q.pop_front();
          if (bad < 0 && samples[i] != w) begin
            bad = i;
            got = samples[i];
            want = w;
          end
        end
        if (bad >= 0) begin
          fails++;
          $display("FAIL vec_data[%0d]: got %f required %f",
                   bad, got, want);
        end
      end
    end
  end

  initial begin
    int sc0;
    int e0;
    int nz;
    set_params(1'b0);

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", feat_ready, 0);
    chk("rst_valid", vec_valid, 0);
    chk("rst_err", frame_error, 0);
    chk("rst_count", sample_count, 0);
    chkr("rst_sample0", samples[0], 0.0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", feat_ready, 1);
    @(posedge clk);
    #1;

    // basic frame: (3-1)*0.5 = 1.0 everywhere
    vec_ready = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back(1.0);
    for (int i = 0; i < N; i++) beat(3.0, i == N - 1);
    @(negedge clk);
    chk("basic_latency", vec_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("basic_one_cycle", vec_valid, 0);
    chk("basic_count", sample_count, 1);
    @(posedge clk);
    #1;

    // backpressure
    set_params(1'b1);
    vec_ready = 1'b0;
    send_frame(1, N, N - 1, 1'b1);
    send_frame(2, N, N - 1, 1'b1);
    fork
      begin
        send_frame(3, N, N - 1, 1'b1);
        f3_done = 1'b1;
      end
    join_none
    @(negedge clk);
    chk("bp_ready_low", feat_ready, 0);
    chk("bp_valid", vec_valid, 1);
    chkr("bp_first_frame", samples[0], 100.0);
    @(posedge clk);
    #1;
    vec_ready = 1'b1;
    @(posedge clk);
    #1;
    vec_ready = 1'b0;
    @(negedge clk);
    chkr("bp_second_frame", samples[1], 201.0);
    chk("bp_ready_back", feat_ready, 1);
    for (int n = 0; n < 300 && !f3_done; n++) cyc(1);
    chk("bp_f3_done", f3_done, 1);
    @(negedge clk);
    chk("bp_full_again", feat_ready, 0);
    @(posedge clk);
    #1;
    drain();
    chk("bp_count", sample_count, 4);

    // early last on beat 10
    e0 = err_cnt;
    sc0 = sample_count;
    send_frame(9, 11, 10, 1'b0);
    cyc(3);
    @(negedge clk);
    chk("early_err", err_cnt, e0 + 1);
    chk("early_no_valid", vec_valid, 0);
    chk("early_count", sample_count, sc0);
    @(posedge clk);
    #1;
    send_frame(4, N, N - 1, 1'b1);
    drain();
    chk("early_next_count", sample_count, sc0 + 1);

    // missing last, then 5-beat tail, then a good frame
    e0 = err_cnt;
    sc0 = sample_count;
    send_frame(8, N, -1, 1'b0);
    send_frame(8, 5, 4, 1'b0);
    send_frame(5, N, N - 1, 1'b1);
    drain();
    chk("miss_err", err_cnt, e0 + 1);
    chk("miss_count", sample_count, sc0 + 1);

    // completion of frame 7 and handoff of frame 6 on one edge
    vec_ready = 1'b0;
    send_frame(6, N, N - 1, 1'b1);
    for (int i = 0; i < N; i++) exp_q.push_back(ev(7, i));
    for (int i = 0; i < N - 1; i++) beat(dv(7, i), 1'b0);
    sc0 = sample_count;
    feat_valid = 1'b1;
    feat_data  = dv(7, N - 1);
    feat_last  = 1'b1;
    vec_ready  = 1'b1;
    @(negedge clk);
    chk("sim_ready_pre", feat_ready, 1);
    @(posedge clk);
    #1;
    feat_valid = 1'b0;
    feat_last  = 1'b0;
    vec_ready  = 1'b0;
    @(negedge clk);
    chk("sim_valid", vec_valid, 1);
    chkr("sim_frame_b", samples[N-1], ev(7, N - 1));
    chk("sim_ready", feat_ready, 1);
    chk("sim_count", sample_count, sc0 + 1);
    @(posedge clk);
    #1;
    drain();

    // reset mid-frame with one vector pending
    vec_ready = 1'b0;
    send_frame(10, N, N - 1, 1'b0);
    send_frame(11, 16, -1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", vec_valid, 0);
    chk("mid_rst_count", sample_count, 0);
    nz = 0;
    for (int i = 0; i < N; i++) if (samples[i] != 0.0) nz++;
    chk("mid_rst_nonzero", nz, 0);
    @(posedge clk);
    #1;
    vec_ready = 1'b1;
    send_frame(12, N, N - 1, 1'b1);
    drain();
    chk("mid_rst_after", sample_count, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
